systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Read-out end of the systolic matrix-multiply array.
- On `start`, snapshots the array's SIZE x SIZE grid of 32-bit accumulators into a shadow bank and pulses `acc_clr` so the array can be cleared and reused.
- Streams the snapshot out one word per transfer, row-major, over a valid/ready interface to the downstream writer or memory.

Parameters:
- SIZE, 4, array dimension; grid is SIZE x SIZE; legal values 2..16
- W, 32, accumulator and output data width
- IW, $clog2(SIZE) (minimum 1), width of the row/column index outputs

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  request to snapshot and drain; honoured only in IDLE
- acc_in  input  W x [0:SIZE-1][0:SIZE-1]  accumulator grid from the array; acc_in[r][c] = C[r][c]
- acc_clr  output  1  one-cycle pulse telling the array controller to clear the accumulators
- out_data  output  W  current word, value shadow[row][col]
- out_row  output  IW  row index of out_data
- out_col  output  IW  column index of out_data
- out_valid  output  1  out_data, out_row, out_col and out_last are valid
- out_ready  input  1  downstream accepts the word
- out_last  output  1  high with the final word (row = col = SIZE-1)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the final word is accepted
- overrun  output  1  sticky flag: `start` arrived while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; row=col=0; shadow bank cleared to 0.
  - acc_clr, out_valid, out_last, busy, done, overrun all 0; out_data=0.
  - Reset asserted mid-stream aborts the stream immediately: no done pulse, and the remaining words are lost.
- States: IDLE, STREAM.
- IDLE:
  - If start=1 at a rising edge: shadow <= acc_in (all words in that edge), row<=0, col<=0, state<=STREAM.
  - acc_clr is registered: high for exactly the one cycle after the capturing edge.
- STREAM:
  - out_valid=1 combinationally from state; out_data=shadow[row][col].
  - Transfer ("fire") = out_valid & out_ready at a rising edge.
  - On fire: col<=col+1. When col=SIZE-1, col<=0 and row<=row+1.
  - On fire with row=col=SIZE-1 (out_last=1): state<=IDLE, and done is high for the next cycle.
  - No fire: out_data, out_row, out_col and out_last hold stable. Once valid is asserted it never drops until the transfer completes.
- Latency:
  - start edge -> out_valid high in the following cycle.
  - Unstalled, SIZE*SIZE consecutive cycles of transfers; done in the cycle after the last transfer.
  - Minimum start-to-done is SIZE*SIZE+1 cycles.
- out_row and out_col equal the internal counters; out_last = (row==SIZE-1)&&(col==SIZE-1)&&out_valid.
- Snapshot isolation: acc_in changes after the capturing edge (including the acc_clr-driven clear) never affect streamed data.
- Boundary conditions:
  - start while busy (STREAM): ignored, state unchanged; overrun<=1 and stays 1 until reset.
  - start in the cycle done is high: state is IDLE, so it is accepted normally (back-to-back drains allowed).
  - start held high continuously: each time IDLE is entered, a new snapshot is taken at the next edge. No overrun is raised from the IDLE cycle.
  - out_ready high while out_valid=0: no effect.
  - Counters never exceed SIZE-1; no wrap-around beyond the last word.
- Arithmetic: data is passed through unchanged at W bits; no sign or width conversion.

Test Plan:
- SIZE=4, acc_in[r][c]=16*r+c, pulse start, out_ready=1 -> 16 transfers in consecutive cycles, values 0,1,2,3,16,…,51 with matching row/col; out_last only on 51; acc_clr one cycle after start; done one cycle after the last transfer.
- Same grid, out_ready toggling 1,0,0,1,… -> identical 16-word sequence; out_data/row/col held stable during every ready=0 cycle; done only after word 51.
- Capture, then on the next cycle change acc_in to all 0xFFFFFFFF -> streamed data is still 16*r+c.
- start re-pulsed at transfer 5 -> stream unaffected, overrun=1 and stays 1 after done; a later start in IDLE drains a new snapshot with overrun still 1.
- reset driven low after transfer 7 -> out_valid, busy and acc_clr drop to 0 immediately; no done pulse; a subsequent start drains a fresh grid from (0,0).
- SIZE=2, start asserted in the cycle done is high -> second drain begins with no idle gap; 4+4 words in order, two done pulses.

Source files
------------

// File: rtl/systolic_drain_if.sv
// Valid/ready word stream carrying one accumulator value plus its grid coordinates.
interface systolic_drain_if #(
    parameter int W  = 32,
    parameter int IW = 2
);
    logic [W-1:0]  data;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          valid;
    logic          ready;
    logic          last;

    modport master (output data, row, col, valid, last, input  ready);
    modport slave  (input  data, row, col, valid, last, output ready);
endinterface

// File: rtl/systolic_drain.sv
// Snapshots the systolic array's accumulator grid into a shadow bank and streams
// it out row-major, one word per valid/ready transfer.
module systolic_drain #(
    parameter int SIZE = 4,
    parameter int W    = 32,
    parameter int IW   = (SIZE > 2) ? $clog2(SIZE) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [0:SIZE-1][0:SIZE-1][W-1:0]    acc_in,
    output logic                                acc_clr,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun,
    systolic_drain_if.master                    stream
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    state_t                              state, state_next;
    logic [0:SIZE-1][0:SIZE-1][W-1:0]    shadow;
    logic [IW-1:0]                       row, col;
    logic                                capture, fire, at_last, valid;

    assign at_last = (row == LAST_IDX) && (col == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        capture    = 1'b0;
        fire       = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                valid = 1'b1;
                fire  = stream.ready;
                if (fire && at_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow bank, read pointer and the registered side-band pulses/flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shadow bank is reset too, so out_data reads 0 after reset rather than stale data.
            shadow  <= '0;
            row     <= '0;
            col     <= '0;
            acc_clr <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            acc_clr <= capture;
            done    <= fire && at_last;
            if (start && (state == STREAM)) overrun <= 1'b1;

            if (capture) begin
                shadow <= acc_in;
                row    <= '0;
                col    <= '0;
            end else if (fire) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    // The final transfer returns the pointer to (0,0) instead of running past the grid.
                    row <= (row == LAST_IDX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign stream.valid = valid;
    assign stream.data  = shadow[row][col];
    assign stream.row   = row;
    assign stream.col   = col;
    assign stream.last  = at_last && valid;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a SIZE=4 instance for the main drains and a
// SIZE=2 instance for back-to-back drains started in the done cycle.
module tb_systolic_drain;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // SIZE = 4 instance
    logic                       start4 = 1'b0;
    logic [0:3][0:3][31:0]      acc4 = '0;
    logic                       ready4 = 1'b0;
    logic                       acc_clr4, busy4, done4, overrun4;
    systolic_drain_if #(.W(32), .IW(2)) bus4 ();
    assign bus4.ready = ready4;

    systolic_drain #(.SIZE(4), .W(32)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .start   (start4),
        .acc_in  (acc4),
        .acc_clr (acc_clr4),
        .busy    (busy4),
        .done    (done4),
        .overrun (overrun4),
        .stream  (bus4.master)
    );

    // SIZE = 2 instance
    logic                       start2 = 1'b0;
    logic [0:1][0:1][31:0]      acc2 = '0;
    logic                       ready2 = 1'b0;
    logic                       acc_clr2, busy2, done2, overrun2;
    systolic_drain_if #(.W(32), .IW(1)) bus2 ();
    assign bus2.ready = ready2;

    systolic_drain #(.SIZE(2), .W(32)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
        .acc_in  (acc2),
        .acc_clr (acc_clr2),
        .busy    (busy2),
        .done    (done2),
        .overrun (overrun2),
        .stream  (bus2.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One SIZE=4 drain of grid base+16r+c. mode 0: ready always 1, mode 1: ready 1,0,0 repeating.
    // clobber overwrites acc_in right after capture; restart_at / abort_at are transfer counts (-1 = off).
    task automatic drain4(input int mode, input bit clobber, input int restart_at,
                          input int abort_at, input logic [31:0] base);
        int k = 0;
        int cyc = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc4[r][c] = base + 32'(16 * r + c);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("acc_clr_after_capture", {31'b0, acc_clr4}, 32'd1);
        check("busy_after_capture", {31'b0, busy4}, 32'd1);
        if (clobber) acc4 = '1;
        while (k < 16 && cyc < 200) begin
            check("valid", {31'b0, bus4.valid}, 32'd1);
            check("row", {30'b0, bus4.row}, 32'(k / 4));
            check("col", {30'b0, bus4.col}, 32'(k % 4));
            check("data", bus4.data, base + 32'(16 * (k / 4) + (k % 4)));
            check("last", {31'b0, bus4.last}, {31'b0, k == 15});
            check("no_early_done", {31'b0, done4}, 32'd0);
            ready4 = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (k == restart_at) start4 = 1'b1;
            step();
            if (start4) begin
                start4 = 1'b0;
                check("overrun_set", {31'b0, overrun4}, 32'd1);
            end
            if (cyc == 0) check("acc_clr_one_cycle", {31'b0, acc_clr4}, 32'd0);
            if (ready4) k++;
            cyc++;
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_valid", {31'b0, bus4.valid}, 32'd0);
                check("abort_busy", {31'b0, busy4}, 32'd0);
                check("abort_acc_clr", {31'b0, acc_clr4}, 32'd0);
                check("abort_overrun", {31'b0, overrun4}, 32'd0);
                check("abort_data", bus4.data, 32'd0);
                step();
                check("abort_no_done", {31'b0, done4}, 32'd0);
                reset = 1'b1;
                step();
                check("abort_no_done_after", {31'b0, done4}, 32'd0);
                return;
            end
        end
        check("drain_complete", 32'(k), 32'd16);
        check("done_pulse", {31'b0, done4}, 32'd1);
        check("idle_valid", {31'b0, bus4.valid}, 32'd0);
        check("idle_busy", {31'b0, busy4}, 32'd0);
        check("idle_row", {30'b0, bus4.row}, 32'd0);
        check("idle_col", {30'b0, bus4.col}, 32'd0);
        step();
        check("done_one_cycle", {31'b0, done4}, 32'd0);
        check("idle_stays", {31'b0, busy4}, 32'd0);
        ready4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        logic [31:0] exp2;
        #2;
        check("rst_valid", {31'b0, bus4.valid}, 32'd0);
        check("rst_busy", {31'b0, busy4}, 32'd0);
        check("rst_acc_clr", {31'b0, acc_clr4}, 32'd0);
        check("rst_done", {31'b0, done4}, 32'd0);
        check("rst_overrun", {31'b0, overrun4}, 32'd0);
        check("rst_last", {31'b0, bus4.last}, 32'd0);
        check("rst_data", bus4.data, 32'd0);
        step();
        reset = 1'b1;
        ready4 = 1'b1;
        step();
        check("idle_ready_no_effect", {31'b0, bus4.valid}, 32'd0);

        drain4(0, 1'b0, -1, -1, 32'd0);           // straight drain
        drain4(1, 1'b0, -1, -1, 32'd0);           // stalled drain
        drain4(0, 1'b1, -1, -1, 32'd0);           // snapshot isolation
        drain4(0, 1'b0, 5, -1, 32'd0);            // start while busy
        check("overrun_sticky", {31'b0, overrun4}, 32'd1);
        drain4(0, 1'b0, -1, -1, 32'hA000_0000);
        check("overrun_still", {31'b0, overrun4}, 32'd1);
        drain4(0, 1'b0, -1, 7, 32'd0);            // reset mid-stream
        drain4(0, 1'b0, -1, -1, 32'h0000_0200);
        check("overrun_cleared", {31'b0, overrun4}, 32'd0);

        // SIZE = 2: second start lands in the done cycle
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                acc2[r][c] = 32'h100 + 32'(2 * r + c);
        ready2 = 1'b1;
        dones = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                acc2[r][c] = 32'h200 + 32'(2 * r + c);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                exp2 = ((d == 0) ? 32'h100 : 32'h200) + 32'(k);
                check("s2_valid", {31'b0, bus2.valid}, 32'd1);
                check("s2_data", bus2.data, exp2);
                check("s2_row", {31'b0, bus2.row}, 32'(k / 2));
                check("s2_col", {31'b0, bus2.col}, 32'(k % 2));
                check("s2_last", {31'b0, bus2.last}, {31'b0, k == 3});
                if (done2) dones++;
                step();
            end
            check("s2_done", {31'b0, done2}, 32'd1);
            check("s2_idle_valid", {31'b0, bus2.valid}, 32'd0);
            dones++;
            if (d == 0) begin
                start2 = 1'b1;
                step();
                start2 = 1'b0;
                check("s2_restart_clr", {31'b0, acc_clr2}, 32'd1);
                check("s2_no_overrun", {31'b0, overrun2}, 32'd0);
            end
        end
        step();
        check("s2_done_drop", {31'b0, done2}, 32'd0);
        check("s2_done_count", 32'(dones), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
